func3_serial_seq: RTL and testbench

- Bit-serial sequencer for the team's 3-input / 2-bit-code function cell: f = a^b^c, ~(a&b&c), ~(a|b|c), or ~(a^b^c).
- Accepts two WIDTH-bit operands, a carry-in and an op code over a valid/ready handshake.
- Streams operand bits LSB-first through one cell instance, one bit per clock, and assembles the result.
- For code 00, sequences the carry chain so the block acts as a WIDTH-bit serial adder.

---
 rtl/func3_pkg.sv | 16 +
 rtl/func3_cell.sv | 27 ++
 rtl/func3_serial_seq.sv | 104 ++++++++++
 tb/tb_func3_serial_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/func3_pkg.sv
// Shared definitions for the 3-input function cell and its bit-serial sequencer.
// Holds the op codes and the sequencer state encoding.
package func3_pkg;

  localparam logic [1:0] CODE_SUM  = 2'b00;
  localparam logic [1:0] CODE_NAND = 2'b01;
  localparam logic [1:0] CODE_NOR  = 2'b10;
  localparam logic [1:0] CODE_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/func3_cell.sv
// Combinational 3-input function cell: one of four 2-bit-coded functions of a/b/c,
// plus the majority of a/b/c used as the carry when chained as a full adder.
module func3_cell
  import func3_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [1:0] code,
  output logic       f,
  output logic       maj
);

  always_comb begin
    f = 1'b0;
    case (code)
      CODE_SUM:  f = a ^ b ^ c;
      CODE_NAND: f = ~(a & b & c);
      CODE_NOR:  f = ~(a | b | c);
      CODE_XNOR: f = ~(a ^ b ^ c);
      default:   f = 1'b0;
    endcase
  end

  assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/func3_serial_seq.sv
// Bit-serial sequencer: streams two WIDTH-bit operands LSB-first through one func3_cell,
// chaining the carry for the sum code so the block behaves as a serial adder.
module func3_serial_seq
  import func3_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_code,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result;
  logic [1:0]       code_reg;
  logic             c_reg;
  logic             cout_q;
  logic             bit_f;
  logic             bit_maj;

  func3_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (c_reg),
    .code (code_reg),
    .f    (bit_f),
    .maj  (bit_maj)
  );

  // Shift right and insert at the MSB; written without slicing so WIDTH=1 elaborates.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic msb);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = msb;
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      result   <= '0;
      code_reg <= CODE_SUM;
      c_reg    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start_valid) begin
            a_sh     <= i_a;
            b_sh     <= i_b;
            code_reg <= i_code;
            c_reg    <= i_cin;
            cnt      <= '0;
            result   <= '0;
            cout_q   <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result <= shift_in(result, bit_f);
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          // Only the sum code chains the carry; other codes keep the latched constant.
          if (code_reg == CODE_SUM) c_reg <= bit_maj;
          if (cnt == LAST_BIT) begin
            cout_q <= (code_reg == CODE_SUM) ? bit_maj : 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (i_res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_start_ready = (state == IDLE);
  assign o_res_valid   = (state == DONE);
  assign o_busy        = (state != IDLE);
  assign o_result      = result;
  assign o_cout        = cout_q;

endmodule

// File: tb/tb_func3_serial_seq.sv
// Bench for func3_serial_seq: table-driven vectors through a scoreboard queue,
// plus hand-written backpressure, reset-mid-op and back-to-back sequences.
module tb_func3_serial_seq;

  localparam int WIDTH = 8;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start_valid = 1'b0;
  logic             o_start_ready;
  logic [WIDTH-1:0] i_a = '0;
  logic [WIDTH-1:0] i_b = '0;
  logic             i_cin = 1'b0;
  logic [1:0]       i_code = 2'b00;
  logic             o_res_valid;
  logic             i_res_ready = 1'b0;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_busy;

  func3_serial_seq #(.WIDTH(WIDTH)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start_valid (i_start_valid),
    .o_start_ready (o_start_ready),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_cin         (i_cin),
    .i_code        (i_code),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready),
    .o_result      (o_result),
    .o_cout        (o_cout),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       code;
    logic [WIDTH-1:0] res;
    logic             cout;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    int               edge_n;
  } exp_t;

  exp_t             sb[$];
  int               acc_log[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_pop = 0;
  int               cyc = 0;
  logic             prev_v = 1'b0;
  logic [WIDTH-1:0] next_res = '0;
  logic             next_cout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: whole-word add or bitwise function with c replicated.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic [1:0] code,
                                output logic [WIDTH-1:0] res, output logic cout);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] c;
    c = {WIDTH{cin}};
    cout = 1'b0;
    case (code)
      2'b00: begin s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin}; res = s[WIDTH-1:0]; cout = s[WIDTH]; end
      2'b01: res = ~(a & b & c);
      2'b10: res = ~(a | b | c);
      default: res = ~(a ^ b ^ c);
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge between input updates.
  always @(negedge clk) begin
    if (i_rst) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      if (i_start_valid && o_start_ready) begin
        sb.push_back('{res: next_res, cout: next_cout, edge_n: cyc + 1});
        acc_log.push_back(cyc + 1);
      end
      if (o_res_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - sb[0].edge_n), 64'(WIDTH));
      end
      if (o_res_valid && i_res_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          check("result", 64'(o_result), 64'(sb[0].res));
          check("cout", 64'(o_cout), 64'(sb[0].cout));
          void'(sb.pop_front());
        end
        n_pop++;
      end
      prev_v = o_res_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int n0);
    int t = 0;
    while (acc_log.size() == n0 && t < TMO) begin step(); t++; end
    if (acc_log.size() == n0) check("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_pop(input int p0);
    int t = 0;
    while (n_pop == p0 && t < TMO) begin step(); t++; end
    if (n_pop == p0) check("result_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input vec_t v);
    int n0;
    int p0;
    n0 = acc_log.size();
    p0 = n_pop;
    i_a = v.a; i_b = v.b; i_cin = v.cin; i_code = v.code;
    next_res = v.res; next_cout = v.cout;
    i_start_valid = 1'b1;
    i_res_ready = 1'b1;
    wait_accept(n0);
    i_start_valid = 1'b0;
    i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_code = 2'($urandom); i_cin = ~i_cin;
    wait_pop(p0);
    check("ready_after_hs", 64'(o_start_ready), 64'd1);
    check("valid_after_hs", 64'(o_res_valid), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t             v;
    logic [WIDTH-1:0] snap_res;
    logic             snap_cout;
    int               n0;
    int               p0;
    int               t;

    vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, code: 2'b00, res: 8'h96, cout: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, code: 2'b00, res: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'hFF, b: 8'h00, cin: 1'b1, code: 2'b00, res: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'hF0, b: 8'hCC, cin: 1'b1, code: 2'b01, res: 8'h3F, cout: 1'b0});
    vecs.push_back('{a: 8'h0F, b: 8'h30, cin: 1'b0, code: 2'b10, res: 8'hC0, cout: 1'b0});
    vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, code: 2'b11, res: 8'h99, cout: 1'b0});
    vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b1, code: 2'b00, res: 8'h01, cout: 1'b1});
    vecs.push_back('{a: 8'hAA, b: 8'h55, cin: 1'b1, code: 2'b01, res: 8'hFF, cout: 1'b0});
    for (int i = 0; i < 6; i++) begin
      v.a = WIDTH'($urandom); v.b = WIDTH'($urandom);
      v.cin = 1'($urandom); v.code = 2'($urandom);
      model(v.a, v.b, v.cin, v.code, v.res, v.cout);
      vecs.push_back(v);
    end

    // Reset state
    step(); step();
    i_rst = 1'b0;
    check("rst_start_ready", 64'(o_start_ready), 64'd1);
    check("rst_res_valid", 64'(o_res_valid), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_cout", 64'(o_cout), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure in DONE while inputs toggle
    n0 = acc_log.size();
    p0 = n_pop;
    i_a = 8'h5A; i_b = 8'h3C; i_cin = 1'b0; i_code = 2'b00;
    next_res = 8'h96; next_cout = 1'b0;
    i_res_ready = 1'b0;
    i_start_valid = 1'b1;
    wait_accept(n0);
    i_start_valid = 1'b0;
    t = 0;
    while (!o_res_valid && t < TMO) begin step(); t++; end
    check("bp_valid_rise", 64'(o_res_valid), 64'd1);
    snap_res = o_result;
    snap_cout = o_cout;
    check("bp_snap_result", 64'(snap_res), 64'h96);
    for (int k = 0; k < 5; k++) begin
      i_start_valid = ~i_start_valid;
      i_a = WIDTH'($urandom);
      step();
      check("bp_valid_hold", 64'(o_res_valid), 64'd1);
      check("bp_result_hold", 64'(o_result), 64'(snap_res));
      check("bp_cout_hold", 64'(o_cout), 64'(snap_cout));
      check("bp_no_ready", 64'(o_start_ready), 64'd0);
    end
    i_start_valid = 1'b0;
    check("bp_no_accept", 64'(acc_log.size()), 64'(n0 + 1));
    i_res_ready = 1'b1;
    wait_pop(p0);
    check("bp_idle", 64'(o_start_ready), 64'd1);
    check("bp_result_keep", 64'(o_result), 64'h96);

    // Reset after 3 RUN edges discards the partial result
    n0 = acc_log.size();
    i_a = 8'hFF; i_b = 8'h01; i_cin = 1'b0; i_code = 2'b00;
    i_start_valid = 1'b1;
    wait_accept(n0);
    i_start_valid = 1'b0;
    step(); step(); step();
    check("mid_busy", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("mid_rst_result", 64'(o_result), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_ready", 64'(o_start_ready), 64'd1);
    check("mid_rst_valid", 64'(o_res_valid), 64'd0);
    run_op('{a: 8'h01, b: 8'h01, cin: 1'b0, code: 2'b00, res: 8'h02, cout: 1'b0});

    // Back-to-back with valid held high
    n0 = acc_log.size();
    p0 = n_pop;
    i_a = 8'h12; i_b = 8'h34; i_cin = 1'b1; i_code = 2'b00;
    next_res = 8'h47; next_cout = 1'b0;
    i_res_ready = 1'b1;
    i_start_valid = 1'b1;
    wait_accept(n0);
    i_a = 8'hC3; i_b = 8'h5A; i_cin = 1'b0; i_code = 2'b10;
    next_res = 8'h24; next_cout = 1'b0;
    wait_accept(n0 + 1);
    i_start_valid = 1'b0;
    if (acc_log.size() >= n0 + 2)
      check("b2b_spacing", 64'(acc_log[n0 + 1] - acc_log[n0]), 64'(WIDTH + 2));
    else
      check("b2b_second_accept", 64'(acc_log.size()), 64'(n0 + 2));
    wait_pop(p0 + 1);
    check("b2b_pops", 64'(n_pop), 64'(p0 + 2));

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
